// File: rtl/rt_line_scheduler.sv
// Per-line raytracing scheduler: N-sphere scene store, per-line setup terms, worker handshake, line publish.
// Optional RT_SCENE_DOUBLE_BUFFER_EN: shadow scene committed at frame start instead of IDLE/pending writes.
module rt_line_scheduler #(
  parameter int JOBS      = 640,
  parameter int N_WORKERS = 10,
  parameter int N_SPHERES = 4,
  parameter int COLOR_W   = 12,
  parameter int Y_W       = 12,
  parameter int Y_CENTER  = 240,
  parameter int IDX_W     = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1,
  parameter int OVR_W     = 16
) (
  input  logic                          CLK100MHZ,
  input  logic                          ck_rst_,
  input  logic                          recv_dv,
  input  logic [IDX_W-1:0]              recv_idx,
  input  logic [63:0]                   recv_64bit,
  output logic                          recv_interrupt,
  input  logic                          next_line,
  input  logic [Y_W-1:0]                next_y,
  output logic [64*N_SPHERES-1:0]       scene,
  output logic signed [Y_W-1:0]         pixel_y,
  output logic [2*Y_W-1:0]              pixely_sq,
  output logic [(Y_W+14)*N_SPHERES-1:0] doty,
  output logic [28*N_SPHERES-1:0]       originy_sq,
  output logic                          workers_activate,
  input  logic [N_WORKERS-1:0]          worker_busy,
  input  logic [JOBS*COLOR_W-1:0]       line_in,
  output logic [JOBS*COLOR_W-1:0]       line_out,
  output logic                          line_done,
  output logic [OVR_W-1:0]              overrun_count
);

  localparam int DW = Y_W + 14;
  localparam int PW = 2 * Y_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LAUNCH,
    S_RENDER,
    S_COMMIT
  } state_t;

  state_t state, state_n;

  logic [63:0]           scene_r [N_SPHERES];
  logic signed [DW-1:0]  doty_r  [N_SPHERES];
  logic [27:0]           osq_r   [N_SPHERES];
  logic                  next_line_q;
  logic                  req_edge;
  logic                  accept;
  logic                  wr_ok;
  logic [Y_W-1:0]        y_lat;
  logic [IDX_W-1:0]      setup_idx;
  logic signed [Y_W-1:0] py_c;
  logic signed [13:0]    sel_y;
  logic signed [DW-1:0]  doty_p;
  logic signed [27:0]    osq_p;
  logic signed [PW-1:0]  psq_p;
  logic                  irq_q;

  assign req_edge       = next_line && !next_line_q;
  assign accept         = (state == S_IDLE) && req_edge;
  assign wr_ok          = recv_dv && (int'(recv_idx) < N_SPHERES);
  assign recv_interrupt = irq_q;

  // One shared multiplier pair walks the slots during SETUP.
  assign py_c   = $signed(y_lat - Y_W'(Y_CENTER));
  assign doty_p = DW'(py_c) * DW'(sel_y);
  assign osq_p  = 28'(sel_y) * 28'(sel_y);
  assign psq_p  = PW'(py_c) * PW'(py_c);

  always_comb begin
    sel_y = '0;
    for (int unsigned k = 0; k < N_SPHERES; k++) begin
      if (setup_idx == IDX_W'(k)) sel_y = scene_r[k][47:34];
    end
  end

  always_comb begin
    state_n          = state;
    workers_activate = 1'b0;
    line_done        = 1'b0;
    case (state)
      S_IDLE:   if (req_edge) state_n = S_SETUP;
      S_SETUP:  if (setup_idx == IDX_W'(N_SPHERES - 1)) state_n = S_LAUNCH;
      S_LAUNCH: begin
        workers_activate = 1'b1;
        if (|worker_busy) state_n = S_RENDER;
      end
      S_RENDER: if (!(|worker_busy)) state_n = S_COMMIT;
      S_COMMIT: begin
        line_done = 1'b1;
        state_n   = S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!ck_rst_) begin
      state         <= S_IDLE;
      next_line_q   <= 1'b0;
      y_lat         <= '0;
      setup_idx     <= '0;
      pixel_y       <= '0;
      pixely_sq     <= '0;
      doty_r        <= '{default: '0};
      osq_r         <= '{default: '0};
      line_out      <= '0;
      overrun_count <= '0;
    end else begin
      state       <= state_n;
      next_line_q <= next_line;
      if (accept) begin
        y_lat     <= next_y;
        setup_idx <= '0;
      end
      if (state == S_SETUP) begin
        if (setup_idx == '0) begin
          pixel_y   <= py_c;
          pixely_sq <= psq_p;
        end
        for (int unsigned k = 0; k < N_SPHERES; k++) begin
          if (setup_idx == IDX_W'(k)) begin
            doty_r[k] <= doty_p;
            osq_r[k]  <= osq_p;
          end
        end
        setup_idx <= setup_idx + 1'b1;
      end
      if (state == S_RENDER && state_n == S_COMMIT) line_out <= line_in;
      if (req_edge && state != S_IDLE && overrun_count != '1)
        overrun_count <= overrun_count + 1'b1;
    end
  end

`ifdef RT_SCENE_DOUBLE_BUFFER_EN
  logic [63:0] shadow_r [N_SPHERES];

  // Copy uses the pre-edge shadow, so a same-cycle write only reaches shadow.
  always_ff @(posedge CLK100MHZ) begin
    if (!ck_rst_) begin
      scene_r  <= '{default: '0};
      shadow_r <= '{default: '0};
      irq_q    <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      if (accept && next_y == '0) begin
        scene_r <= shadow_r;
        irq_q   <= 1'b1;
      end
      for (int unsigned k = 0; k < N_SPHERES; k++) begin
        if (wr_ok && recv_idx == IDX_W'(k)) shadow_r[k] <= recv_64bit;
      end
    end
  end
`else
  logic             pend_v;
  logic             pend_next;
  logic [IDX_W-1:0] pend_idx;
  logic [63:0]      pend_data;

  always_comb begin
    pend_next = pend_v;
    if (state == S_IDLE || state == S_COMMIT) pend_next = 1'b0;
    else if (wr_ok)                           pend_next = 1'b1;
  end

  // Pending drains on the COMMIT->IDLE edge; a fresh write in that cycle lands last.
  always_ff @(posedge CLK100MHZ) begin
    if (!ck_rst_) begin
      scene_r   <= '{default: '0};
      pend_v    <= 1'b0;
      pend_idx  <= '0;
      pend_data <= '0;
      irq_q     <= 1'b0;
    end else begin
      pend_v <= pend_next;
      irq_q  <= (state_n == S_IDLE) && !pend_next;
      if (state == S_IDLE || state == S_COMMIT) begin
        for (int unsigned k = 0; k < N_SPHERES; k++) begin
          if (pend_v && pend_idx == IDX_W'(k)) scene_r[k] <= pend_data;
          if (wr_ok && recv_idx == IDX_W'(k))  scene_r[k] <= recv_64bit;
        end
      end else if (wr_ok) begin
        pend_idx  <= recv_idx;
        pend_data <= recv_64bit;
      end
    end
  end
`endif

  always_comb begin
    scene      = '0;
    doty       = '0;
    originy_sq = '0;
    for (int unsigned k = 0; k < N_SPHERES; k++) begin
      scene[k*64 +: 64]      = scene_r[k];
      doty[k*DW +: DW]       = doty_r[k];
      originy_sq[k*28 +: 28] = osq_r[k];
    end
  end

endmodule

// File: tb/tb_rt_line_scheduler.sv
// Self-checking bench for rt_line_scheduler: worker model, line scoreboard, per-scenario tasks.
module tb_rt_line_scheduler;
  localparam int JOBS = 640, N_WORKERS = 10, N_SPHERES = 4, COLOR_W = 12;
  localparam int Y_W = 12, Y_CENTER = 240, IDX_W = 3, OVR_W = 4;
  localparam int DW = Y_W + 14;
  localparam int OVR_MAX = (1 << OVR_W) - 1;

  logic CLK100MHZ = 1'b0;
  logic ck_rst_ = 1'b0;
  logic recv_dv = 1'b0;
  logic [IDX_W-1:0] recv_idx = '0;
  logic [63:0] recv_64bit = '0;
  logic recv_interrupt;
  logic next_line = 1'b0;
  logic [Y_W-1:0] next_y = '0;
  logic [64*N_SPHERES-1:0] scene;
  logic signed [Y_W-1:0] pixel_y;
  logic [2*Y_W-1:0] pixely_sq;
  logic [DW*N_SPHERES-1:0] doty;
  logic [28*N_SPHERES-1:0] originy_sq;
  logic workers_activate;
  logic [N_WORKERS-1:0] worker_busy = '0;
  logic [JOBS*COLOR_W-1:0] line_in;
  logic [JOBS*COLOR_W-1:0] line_out;
  logic line_done;
  logic [OVR_W-1:0] overrun_count;

  always #5 CLK100MHZ = ~CLK100MHZ;

  rt_line_scheduler #(
    .JOBS(JOBS), .N_WORKERS(N_WORKERS), .N_SPHERES(N_SPHERES), .COLOR_W(COLOR_W),
    .Y_W(Y_W), .Y_CENTER(Y_CENTER), .IDX_W(IDX_W), .OVR_W(OVR_W)
  ) dut (
    .CLK100MHZ(CLK100MHZ), .ck_rst_(ck_rst_), .recv_dv(recv_dv), .recv_idx(recv_idx),
    .recv_64bit(recv_64bit), .recv_interrupt(recv_interrupt), .next_line(next_line),
    .next_y(next_y), .scene(scene), .pixel_y(pixel_y), .pixely_sq(pixely_sq), .doty(doty),
    .originy_sq(originy_sq), .workers_activate(workers_activate), .worker_busy(worker_busy),
    .line_in(line_in), .line_out(line_out), .line_done(line_done), .overrun_count(overrun_count)
  );

  typedef struct {
    logic [COLOR_W-1:0] color;
    int                 done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int wk_len = 10;
  bit wk_active = 1'b0;
  logic [N_WORKERS-1:0] busy_mask = '1;
  logic [COLOR_W-1:0] line_color = '0;
  logic [64*N_SPHERES-1:0] exp_scene = '0;
  int sy[N_SPHERES] = '{37, -100, 8000, -8192};

  assign line_in = {JOBS{line_color}};

  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  task automatic tick();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic at_neg(input int target);
    while (cyc < target) tick();
    @(negedge CLK100MHZ);
  endtask

  function automatic logic [63:0] mk_sph(input int k, input int y);
    logic [13:0] yy;
    yy = 14'(y);
    return {16'(k * 1000 + 1), yy, 16'(k + 7), 6'(k + 1), 12'(k * 16 + 3)};
  endfunction

  // Workers: busy rises the cycle after activate is seen and stays up wk_len cycles.
  initial begin
    forever begin
      @(negedge CLK100MHZ);
      if (workers_activate === 1'b1 && !wk_active) begin
        wk_active = 1'b1;
        tick();
        worker_busy = busy_mask;
        repeat (wk_len) @(posedge CLK100MHZ);
        #1 worker_busy = '0;
        wk_active = 1'b0;
      end
    end
  end

  always @(negedge CLK100MHZ) begin : monitor
    exp_t e;
    int bad;
    if (line_done === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL line_done_unexpected: pulse at cycle %0d, required none", cyc);
      end else begin
        e = exp_q.pop_front();
        bad = 0;
        for (int p = 0; p < JOBS; p++)
          if (line_out[p*COLOR_W +: COLOR_W] !== e.color) bad++;
        if (bad != 0) begin
          n_fail++;
          $display("FAIL line_out: %0d pixels wrong, pixel0 got %h required %h", bad,
                   line_out[COLOR_W-1:0], e.color);
        end
        n_checks++;
        if (cyc != e.done_cyc) begin
          n_fail++;
          $display("FAIL line_done_cycle: got %0d required %0d", cyc, e.done_cyc);
        end
      end
    end
  end

  task automatic request(input int y, input int r, input logic [COLOR_W-1:0] color, output int c0);
    exp_t e;
    wk_len = r;
    line_color = color;
    next_y = Y_W'(y);
    next_line = 1'b1;
    c0 = cyc;
    e.color = color;
    e.done_cyc = c0 + N_SPHERES + r + 3;
    exp_q.push_back(e);
    tick();
    next_line = 1'b0;
  endtask

  task automatic pulse_line();
    next_line = 1'b1;
    tick();
    next_line = 1'b0;
    tick();
  endtask

  task automatic write_sph(input int idx, input logic [63:0] d);
    recv_dv = 1'b1;
    recv_idx = IDX_W'(idx);
    recv_64bit = d;
    tick();
    recv_dv = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL line_timeout: %0d lines outstanding after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    int irq_exp;
    ck_rst_ = 1'b0;
    repeat (3) tick();
    at_neg(cyc + 1);
    n_checks++; if (workers_activate !== 1'b0) begin n_fail++; $display("FAIL rst_activate: got %b required 0", workers_activate); end
    n_checks++; if (line_done !== 1'b0) begin n_fail++; $display("FAIL rst_line_done: got %b required 0", line_done); end
    n_checks++; if (line_out !== '0) begin n_fail++; $display("FAIL rst_line_out: pixel0 got %h required 0", line_out[COLOR_W-1:0]); end
    n_checks++; if (overrun_count !== '0) begin n_fail++; $display("FAIL rst_overrun: got %0d required 0", overrun_count); end
    n_checks++; if (scene !== '0) begin n_fail++; $display("FAIL rst_scene: got %h required 0", scene); end
    n_checks++;
    if (pixel_y !== '0 || pixely_sq !== '0 || doty !== '0 || originy_sq !== '0) begin
      n_fail++;
      $display("FAIL rst_setup_regs: pixel_y %h pixely_sq %h doty %h originy_sq %h, required all 0",
               pixel_y, pixely_sq, doty, originy_sq);
    end
    n_checks++; if (recv_interrupt !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b required 0", recv_interrupt); end
    ck_rst_ = 1'b1;
    at_neg(cyc + 2);
`ifdef RT_SCENE_DOUBLE_BUFFER_EN
    irq_exp = 0;
`else
    irq_exp = 1;
`endif
    n_checks++;
    if (recv_interrupt !== 1'(irq_exp)) begin n_fail++; $display("FAIL idle_irq: got %b required %0d", recv_interrupt, irq_exp); end
  endtask

  task automatic test_setup_math();
    int c0, y, py, got, expv;
    for (int k = 0; k < N_SPHERES; k++) begin
      write_sph(k, mk_sph(k, sy[k]));
      exp_scene[k*64 +: 64] = mk_sph(k, sy[k]);
    end
    for (int i = 0; i < 2; i++) begin
      y = (i == 0) ? 0 : 340;
      busy_mask = (i == 0) ? '1 : N_WORKERS'(32);
      request(y, (i == 0) ? 20 : 50, (i == 0) ? 12'h0A5 : 12'hF00, c0);
      at_neg(c0 + N_SPHERES);
      n_checks++; if (workers_activate !== 1'b0) begin n_fail++; $display("FAIL activate_early y=%0d: got %b required 0", y, workers_activate); end
      at_neg(c0 + N_SPHERES + 1);
      n_checks++; if (workers_activate !== 1'b1) begin n_fail++; $display("FAIL activate_on y=%0d: got %b required 1", y, workers_activate); end
      n_checks++; if (scene !== exp_scene) begin n_fail++; $display("FAIL scene_loaded: got %h required %h", scene, exp_scene); end
      py = y - Y_CENTER;
      got = pixel_y;
      n_checks++; if (got != py) begin n_fail++; $display("FAIL pixel_y y=%0d: got %0d required %0d", y, got, py); end
      got = int'(pixely_sq);
      n_checks++; if (got != py * py) begin n_fail++; $display("FAIL pixely_sq y=%0d: got %0d required %0d", y, got, py * py); end
      for (int k = 0; k < N_SPHERES; k++) begin
        got = $signed(doty[k*DW +: DW]);
        expv = py * sy[k];
        n_checks++; if (got != expv) begin n_fail++; $display("FAIL doty[%0d] y=%0d: got %0d required %0d", k, y, got, expv); end
        got = int'(originy_sq[k*28 +: 28]);
        expv = sy[k] * sy[k];
        n_checks++; if (got != expv) begin n_fail++; $display("FAIL originy_sq[%0d]: got %0d required %0d", k, got, expv); end
      end
      wait_drain(N_SPHERES + 80);
    end
    busy_mask = '1;
    at_neg(cyc + 3);
    got = pixel_y;
    n_checks++; if (got != 100) begin n_fail++; $display("FAIL pixel_y_hold: got %0d required 100", got); end
  endtask

  task automatic test_overrun();
    int c0, exp_ovr;
    logic [JOBS*COLOR_W-1:0] exp_line;
    exp_ovr = 0;
    request(100, 30, 12'h0F0, c0);
    at_neg(c0 + 10);
    pulse_line();
    exp_ovr = 1;
    wait_drain(N_SPHERES + 60);
    n_checks++; if (int'(overrun_count) != exp_ovr) begin n_fail++; $display("FAIL overrun_one: got %0d required %0d", overrun_count, exp_ovr); end
    at_neg(cyc + 20);
    exp_line = {JOBS{12'h0F0}};
    n_checks++; if (line_out !== exp_line) begin n_fail++; $display("FAIL line_out_kept: pixel0 got %h required 0f0", line_out[COLOR_W-1:0]); end
    request(200, 80, 12'h00F, c0);
    at_neg(c0 + 9);
    for (int i = 0; i < 20; i++) begin
      pulse_line();
      if (exp_ovr < OVR_MAX) exp_ovr++;
    end
    wait_drain(N_SPHERES + 120);
    n_checks++; if (int'(overrun_count) != exp_ovr) begin n_fail++; $display("FAIL overrun_sat: got %0d required %0d", overrun_count, exp_ovr); end
  endtask

  task automatic test_scene_update();
    int c0, c1, c2;
    logic [63:0] s_new;
    s_new = mk_sph(9, -77);
    request(50, 40, 12'h333, c0);
    at_neg(c0 + 10);
    write_sph(0, s_new);
    at_neg(c0 + 12);
    n_checks++; if (scene !== exp_scene) begin n_fail++; $display("FAIL scene_mid_render: got %h required %h", scene, exp_scene); end
    n_checks++; if (recv_interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_mid_render: got %b required 0", recv_interrupt); end
    wait_drain(N_SPHERES + 60);
`ifdef RT_SCENE_DOUBLE_BUFFER_EN
    request(7, 5, 12'h444, c1);
    at_neg(c1 + 1);
    n_checks++; if (recv_interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_no_copy: got %b required 0", recv_interrupt); end
    wait_drain(N_SPHERES + 30);
    n_checks++; if (scene !== exp_scene) begin n_fail++; $display("FAIL scene_before_frame: got %h required %h", scene, exp_scene); end
    exp_scene[63:0] = s_new;
    request(0, 5, 12'h555, c2);
    at_neg(c2 + 1);
    n_checks++; if (scene !== exp_scene) begin n_fail++; $display("FAIL scene_frame_copy: got %h required %h", scene, exp_scene); end
    n_checks++; if (recv_interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_copy_pulse: got %b required 1", recv_interrupt); end
    at_neg(c2 + 2);
    n_checks++; if (recv_interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_pulse_end: got %b required 0", recv_interrupt); end
    wait_drain(N_SPHERES + 30);
`else
    c1 = c0;
    c2 = c0;
    at_neg(c0 + N_SPHERES + 40 + 5);
    exp_scene[63:0] = s_new;
    n_checks++; if (scene !== exp_scene) begin n_fail++; $display("FAIL scene_pending_apply: got %h required %h", scene, exp_scene); end
    n_checks++; if (recv_interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_idle_after: got %b required 1", recv_interrupt); end
`endif
  endtask

  task automatic test_write_with_request();
    int c0;
    exp_t e;
    logic [63:0] s2;
    s2 = mk_sph(5, 1234);
    wk_len = 6;
    line_color = 12'h6A6;
    recv_dv = 1'b1;
    recv_idx = 3'd2;
    recv_64bit = s2;
    next_y = '0;
    next_line = 1'b1;
    c0 = cyc;
    e.color = 12'h6A6;
    e.done_cyc = c0 + N_SPHERES + 6 + 3;
    exp_q.push_back(e);
    tick();
    recv_dv = 1'b0;
    next_line = 1'b0;
    wait_drain(N_SPHERES + 30);
`ifdef RT_SCENE_DOUBLE_BUFFER_EN
    n_checks++; if (scene !== exp_scene) begin n_fail++; $display("FAIL same_cycle_shadow_only: got %h required %h", scene, exp_scene); end
    exp_scene[2*64 +: 64] = s2;
    request(0, 4, 12'h123, c0);
    wait_drain(N_SPHERES + 30);
`else
    exp_scene[2*64 +: 64] = s2;
`endif
    at_neg(cyc + 1);
    n_checks++; if (scene !== exp_scene) begin n_fail++; $display("FAIL same_cycle_write: got %h required %h", scene, exp_scene); end
  endtask

  task automatic test_bad_idx();
    int c0;
    write_sph(5, 64'hDEAD_BEEF_0BAD_F00D);
    write_sph(4, 64'h1111_2222_3333_4444);
    write_sph(7, 64'h5555_6666_7777_8888);
    at_neg(cyc + 1);
    n_checks++; if (scene !== exp_scene) begin n_fail++; $display("FAIL bad_idx_direct: got %h required %h", scene, exp_scene); end
    request(0, 5, 12'h777, c0);
    wait_drain(N_SPHERES + 30);
    at_neg(cyc + 1);
    n_checks++; if (scene !== exp_scene) begin n_fail++; $display("FAIL bad_idx_commit: got %h required %h", scene, exp_scene); end
  endtask

  task automatic test_reset_mid_render();
    int c0, c1, n;
    request(300, 60, 12'h5A5, c0);
    at_neg(c0 + 20);
    ck_rst_ = 1'b0;
    at_neg(c0 + 21);
    exp_q.delete();
    exp_scene = '0;
    n_checks++; if (workers_activate !== 1'b0) begin n_fail++; $display("FAIL midrst_activate: got %b required 0", workers_activate); end
    n_checks++; if (line_out !== '0) begin n_fail++; $display("FAIL midrst_line_out: pixel0 got %h required 0", line_out[COLOR_W-1:0]); end
    n_checks++; if (overrun_count !== '0) begin n_fail++; $display("FAIL midrst_overrun: got %0d required 0", overrun_count); end
    n_checks++; if (scene !== '0 || pixel_y !== '0) begin n_fail++; $display("FAIL midrst_state: scene %h pixel_y %h required 0", scene, pixel_y); end
    ck_rst_ = 1'b1;
    n = 0;
    while (wk_active && n < 200) begin tick(); n++; end
    n_checks++; if (wk_active) begin n_fail++; $display("FAIL worker_timeout: still busy after %0d cycles, required idle", n); end
    request(120, 5, 12'h999, c1);
    wait_drain(N_SPHERES + 30);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_setup_math();
    test_overrun();
    test_scene_update();
    test_write_with_request();
    test_bad_idx();
    test_reset_mid_render();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
